// File: rtl/fsk_tx_sequencer_pkg.sv
// rtl/fsk_tx_sequencer_pkg.sv - shared types and defaults for the FSK tuning-word sequencer
package fsk_pkg;
    localparam int TW_W_DEF = 32;
    localparam int SPS_DEF  = 16;

    typedef logic [TW_W_DEF-1:0] tw_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;
endpackage

// File: rtl/fsk_tx_sequencer_if.sv
// rtl/fsk_tx_sequencer_if.sv - byte valid/ready handshake into the FSK sequencer
interface fsk_tx_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fsk_tx_sequencer_sym_timer.sv
// rtl/fsk_tx_sequencer_sym_timer.sv - sample/bit counters with last-sample flags
module fsk_sym_timer #(
    parameter int SPS    = 16,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic adv,
    output logic sym_last,
    output logic byte_last
);
    localparam int SC_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SPS - 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(DATA_W - 1);

    logic [SC_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;

    assign sym_last  = (sample_cnt_q == SC_MAX);
    assign byte_last = sym_last && (bit_cnt_q == BC_MAX);

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        if (clear) begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
        end else if (adv) begin
            if (sym_last) begin
                sample_cnt_d = '0;
                bit_cnt_d    = byte_last ? '0 : bit_cnt_q + 1'b1;
            end else begin
                sample_cnt_d = sample_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/fsk_tx_sequencer.sv
// rtl/fsk_tx_sequencer.sv - buffers bytes and drives mark/space tuning words per sample strobe
module fsk_tx_sequencer
    import fsk_pkg::*;
#(
    parameter int TW_W      = TW_W_DEF,
    parameter int DATA_W    = 8,
    parameter int SPS       = SPS_DEF,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_MARK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [TW_W-1:0]   f0_tw,
    input  logic [TW_W-1:0]   f1_tw,
    fsk_tx_sequencer_if.slave bus,
    input  logic              flush,
    output logic [TW_W-1:0]   tw_out,
    output logic              tw_valid,
    output logic              sym_active,
    output logic              sym_bit,
    output logic              byte_done
);
    state_t            state_q;
    logic [DATA_W-1:0] buf_q, shift_q;
    logic              buf_full_q;
    logic [TW_W-1:0]   f0_lat_q, f1_lat_q, tw_out_q;
    logic              tw_valid_q, sym_active_q, sym_bit_q, byte_done_q;

    logic            adv, load, accept, cur_bit, sym_last, byte_last;
    logic [TW_W-1:0] idle_tw;

    assign adv     = sample_en && (state_q == ACTIVE) && !flush;
    // Reload at the last sample of a byte keeps back-to-back bytes gapless.
    assign load    = !flush && buf_full_q && ((state_q == IDLE) || (adv && byte_last));
    assign bus.in_ready = reset && !flush && (!buf_full_q || load);
    assign accept  = bus.in_valid && bus.in_ready;
    assign cur_bit = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
    assign idle_tw = IDLE_MARK ? f1_tw : f0_tw;

    fsk_sym_timer #(.SPS(SPS), .DATA_W(DATA_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush || load),
        .adv       (adv),
        .sym_last  (sym_last),
        .byte_last (byte_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shift_q      <= '0;
            f0_lat_q     <= '0;
            f1_lat_q     <= '0;
            tw_out_q     <= '0;
            tw_valid_q   <= 1'b0;
            sym_active_q <= 1'b0;
            sym_bit_q    <= 1'b0;
            byte_done_q  <= 1'b0;
        end else begin
            tw_valid_q  <= sample_en;
            byte_done_q <= adv && byte_last;
            if (sample_en) begin
                if ((state_q == ACTIVE) && !flush) begin
                    tw_out_q     <= cur_bit ? f1_lat_q : f0_lat_q;
                    sym_active_q <= 1'b1;
                    sym_bit_q    <= cur_bit;
                end else begin
                    tw_out_q     <= idle_tw;
                    sym_active_q <= 1'b0;
                    sym_bit_q    <= 1'b0;
                end
            end
            if (flush) begin
                buf_full_q <= 1'b0;
                shift_q    <= '0;
                state_q    <= IDLE;
            end else begin
                if (accept) begin
                    buf_q      <= bus.in_data;
                    buf_full_q <= 1'b1;
                end else if (load) begin
                    buf_full_q <= 1'b0;
                end
                if (load) begin
                    shift_q  <= buf_q;
                    f0_lat_q <= f0_tw;
                    f1_lat_q <= f1_tw;
                    state_q  <= ACTIVE;
                end else if (adv) begin
                    if (byte_last) begin
                        state_q <= IDLE;
                    end else if (sym_last) begin
                        shift_q <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    end
                end
            end
        end
    end

    assign tw_out     = tw_out_q;
    assign tw_valid   = tw_valid_q;
    assign sym_active = sym_active_q;
    assign sym_bit    = sym_bit_q;
    assign byte_done  = byte_done_q;
endmodule
